// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the memory-mapped UART transmitter
package uart_pkg;
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;
  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU store/load bus into the UART register window
interface uart_tx_mmio_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [1:0] MemWrite;
  logic Sel;
  logic [31:0] RdData;
  modport master (output Addr, WriteData, MemWrite, input Sel, RdData);
  modport slave (input Addr, WriteData, MemWrite, output Sel, RdData);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a same-cycle pop frees the slot a push into a full FIFO needs
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_count;
  logic w_push;
  logic w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage needs no reset: only slots below the count are ever read out
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and pollable status
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           Tx,
  output logic           Irq
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  tx_state_e r_state;
  logic [CW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_ovf;
  logic w_sel;
  logic w_store;
  logic w_data_wr;
  logic w_stat_rd;
  logic w_stat_wr;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_last;
  logic [7:0] w_head;
  logic [AW:0] w_count;
  logic [31:0] w_count32;
  logic [31:0] w_status;
  logic w_unused;
  assign w_sel = bus.Addr[31:3] == BASE_ADDR[31:3];
  assign w_store = bus.MemWrite inside {MW_BYTE, MW_HALF, MW_WORD};
  assign w_data_wr = w_store && w_sel && bus.Addr[2:0] == OFF_DATA;
  assign w_stat_rd = w_sel && bus.Addr[2:0] == OFF_STATUS;
  assign w_stat_wr = w_store && w_stat_rd;
  assign w_pop = r_state == IDLE && !w_empty;
  assign w_last = r_baud == CW'(CPB - 1);
  assign w_count32 = 32'(w_count);
  assign bus.Sel = w_sel;
  assign bus.RdData = w_stat_rd ? w_status : '0;
  assign w_unused = &{1'b0, bus.WriteData[31:8]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_data_wr),
    .i_data(bus.WriteData[7:0]),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  // status word assembled from live FIFO/engine state; count saturates at 15
  always_comb begin
    w_status = '0;
    w_status[ST_BUSY] = r_state != IDLE;
    w_status[ST_FULL] = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF] = r_ovf;
    w_status[ST_CNT +: 4] = w_count32 > 32'd15 ? 4'hF : w_count32[3:0];
  end
  // sticky overflow: set by a dropped push, cleared by writing bit 3 of STATUS
  always_ff @(posedge clk)
    if (!reset) r_ovf <= 1'b0;
    else if (w_stat_wr && bus.WriteData[3]) r_ovf <= 1'b0;
    else if (w_data_wr && w_full && !w_pop) r_ovf <= 1'b1;
  // 8N1 serializer; Tx is driven one cycle ahead from the state being entered
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      Tx <= 1'b1;
      Irq <= 1'b1;
    end else begin
      Irq <= r_state == IDLE && w_empty;
      r_baud <= (r_state == IDLE || w_last) ? '0 : r_baud + 1'b1;
      case (r_state)
        IDLE: if (!w_empty) begin
          r_shift <= w_head;
          r_state <= START;
          Tx <= 1'b0;
        end
        START: if (w_last) begin
          r_state <= DATA;
          r_bit <= '0;
          Tx <= r_shift[0];
        end
        DATA: if (w_last) begin
          if (r_bit == 3'd7) begin
            r_state <= STOP;
            Tx <= 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
            r_shift <= r_shift >> 1;
            Tx <= r_shift[1];
          end
        end
        STOP: if (w_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter. It sits directly downstream of the controller's MemWrite output and the datapath's address/store-data buses.
- CPU stores to the data register queue bytes into a TX FIFO. A bit-serial 8N1 engine drains the FIFO onto the Tx pin.
- A status register is readable combinationally, so a single-cycle load can poll it.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer divide, must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries. Power of two, >= 2.
- BASE_ADDR, 32'h0000_0400, word-aligned base. DATA register at BASE+0, STATUS register at BASE+4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- Addr  in  32  byte address from ALU result.
- WriteData  in  32  store data (rs2).
- MemWrite  in  2  00 none, 01 byte (SB), 10 half (SH), 11 word (SW).
- Sel  out  1  combinational: Addr[31:3] == BASE_ADDR[31:3].
- RdData  out  32  combinational read data: STATUS when Addr == BASE+4, else 0.
- Tx  out  1  serial line, idle high.
- Irq  out  1  registered: FIFO empty and engine idle.

Behaviour:
- Reset values: Tx=1, Irq=1, FIFO empty (pointers 0, count 0), overflow=0, FSM=IDLE, baud counter 0, bit index 0.
- Push condition: MemWrite != 00 and Addr == BASE+0.
  - Pushed byte is WriteData[7:0] for all three store widths; upper bits are ignored.
  - Write effects land on the next rising edge.
- STATUS layout:
  - [0] busy (FSM != IDLE)
  - [1] full
  - [2] empty
  - [3] overflow (sticky)
  - [7:4] count (saturates at 15 if FIFO_DEPTH > 15)
  - [31:8] = 0
- STATUS write (MemWrite != 00, Addr == BASE+4) with WriteData[3]=1 clears overflow. All other bits are read-only.
- Writes to any other address, or misaligned addresses inside the 8-byte window, are ignored.
- Overflow: a push while full with no pop in the same cycle drops the byte and sets overflow=1.
- Simultaneous push and pop:
  - Both are performed; count is unchanged.
  - When full, this push is accepted, with no overflow.
  - When empty, no pop occurs, so only the push applies.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- FSM states IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - IDLE: if FIFO not empty, pop the head into the shift register, go to START, Tx=0 from the next cycle.
  - START: hold Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE. If the FIFO is non-empty at that point, the next START begins one cycle later (one IDLE cycle between frames).
- Frame length: 10*CLKS_PER_BIT cycles plus 1 IDLE cycle per byte.
- Tx and Irq are registered, with no combinational path from inputs.
- Reset asserted mid-frame: the next edge returns Tx=1, FSM=IDLE, FIFO flushed. No partial byte is resumed.

Decomposition:
- Package uart_pkg holds:
  - MemWrite encodings MW_NONE/MW_BYTE/MW_HALF/MW_WORD.
  - Register offsets OFF_DATA=0, OFF_STATUS=4.
  - STATUS bit indices.
  - FSM state encoding (2-bit enum).
- One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count, pop-before-push semantics when full), instantiated with width 8.
- Serializer FSM, decode and status logic stay in uart_tx_mmio.

Test Plan (CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10):
- Reset held 3 cycles then released, no stores -> Tx=1, Irq=1, RdData@BASE+4 = 32'h0000_0004.
- SB 8'hA5 to BASE+0 -> Tx low for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then stop high. busy=1 throughout; Irq returns to 1 after STOP.
- SW 32'h1234_5678 to BASE+0 -> only 8'h78 transmitted, count peaks at 1.
- 10 back-to-back SB while the first frame is running -> first byte popped, FIFO reaches full (count 8), the 10th store sets overflow. STATUS = 32'h0000_008B. SW 32'h8 to BASE+4 clears it to 32'h0000_0083.
- Push coinciding with the IDLE pop while full -> byte accepted, count stays 8, overflow stays 0.
- Reset asserted at cycle 35 of a frame -> Tx=1 on the next edge, count=0, no further frame until a new store.
